// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : pwm_bank
// Description : Multi-channel PWM generator with a shared prescaled period
//               counter and double-buffered TOP/duty/enable/polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_bank #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [4:0]          wr_addr,
    input  logic [31:0]         wr_data,
    input  logic [4:0]          rd_addr,
    output logic [31:0]         rd_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam logic [4:0] c_addr_ctrl  = 5'd0;
    localparam logic [4:0] c_addr_pol   = 5'd1;
    localparam logic [4:0] c_addr_presc = 5'd2;
    localparam logic [4:0] c_addr_top   = 5'd3;

    logic                  run_q, run_d;
    logic [CHANNELS-1:0]   en_q, en_d, pol_q, pol_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic [WIDTH-1:0]      top_q, top_d, cnt_q, cnt_d;
    logic [WIDTH-1:0]      duty_q [CHANNELS];
    logic [WIDTH-1:0]      duty_d [CHANNELS];

    logic [CHANNELS-1:0]   en_s_q, en_s_d, pol_s_q, pol_s_d;
    logic [WIDTH-1:0]      top_s_q, top_s_d;
    logic [WIDTH-1:0]      duty_s_q [CHANNELS];
    logic [WIDTH-1:0]      duty_s_d [CHANNELS];

    logic [CHANNELS-1:0]   pwm_q, pwm_d;
    logic                  ptick_q, ptick_d;
    logic [31:0]           rd_q, rd_d;

    logic                  w_tick, w_wrap;
    logic                  w_unused_wr;

    assign w_unused_wr = ^wr_data;

    // Active register file: software writes land here immediately
    always_comb begin
        run_d   = run_q;
        en_d    = en_q;
        pol_d   = pol_q;
        presc_d = presc_q;
        top_d   = top_q;
        duty_d  = duty_q;
        if (wr_en) begin
            case (wr_addr)
                c_addr_ctrl: begin
                    run_d = wr_data[31];
                    en_d  = wr_data[CHANNELS-1:0];
                end
                c_addr_pol:   pol_d   = wr_data[CHANNELS-1:0];
                c_addr_presc: presc_d = wr_data[PRESCALE_W-1:0];
                c_addr_top:   top_d   = wr_data[WIDTH-1:0];
                default: begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (wr_addr == 5'(4 + k)) duty_d[k] = wr_data[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    assign w_tick = run_q && (pcnt_q == presc_q);
    assign w_wrap = w_tick && (cnt_q == top_s_q);

    always_comb begin
        pcnt_d   = pcnt_q;
        cnt_d    = cnt_q;
        en_s_d   = en_s_q;
        pol_s_d  = pol_s_q;
        top_s_d  = top_s_q;
        duty_s_d = duty_s_q;
        ptick_d  = 1'b0;
        pwm_d    = pol_s_q;
        if (!run_q) begin
            // Idle: counters parked, shadows follow the active registers
            pcnt_d   = '0;
            cnt_d    = '0;
            en_s_d   = en_q;
            pol_s_d  = pol_q;
            top_s_d  = top_q;
            duty_s_d = duty_q;
        end else begin
            pcnt_d = w_tick ? '0 : pcnt_q + 1'b1;
            if (w_wrap) begin
                cnt_d    = '0;
                en_s_d   = en_q;
                pol_s_d  = pol_q;
                top_s_d  = top_q;
                duty_s_d = duty_q;
            end else if (w_tick) begin
                cnt_d = cnt_q + 1'b1;
            end
            ptick_d = w_wrap;
            for (int k = 0; k < CHANNELS; k++) begin
                pwm_d[k] = (en_s_q[k] & (cnt_q < duty_s_q[k])) ^ pol_s_q[k];
            end
        end
    end

    always_comb begin
        rd_d = '0;
        case (rd_addr)
            c_addr_ctrl: begin
                rd_d[CHANNELS-1:0] = en_q;
                rd_d[31]           = run_q;
            end
            c_addr_pol:   rd_d[CHANNELS-1:0]   = pol_q;
            c_addr_presc: rd_d[PRESCALE_W-1:0] = presc_q;
            c_addr_top:   rd_d[WIDTH-1:0]      = top_q;
            default: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (rd_addr == 5'(4 + k)) rd_d[WIDTH-1:0] = duty_q[k];
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q   <= 1'b0;
            en_q    <= '0;
            pol_q   <= '0;
            presc_q <= '0;
            top_q   <= '0;
            en_s_q  <= '0;
            pol_s_q <= '0;
            top_s_q <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            pwm_q   <= '0;
            ptick_q <= 1'b0;
            rd_q    <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                duty_q[k]   <= '0;
                duty_s_q[k] <= '0;
            end
        end else begin
            run_q    <= run_d;
            en_q     <= en_d;
            pol_q    <= pol_d;
            presc_q  <= presc_d;
            top_q    <= top_d;
            duty_q   <= duty_d;
            en_s_q   <= en_s_d;
            pol_s_q  <= pol_s_d;
            top_s_q  <= top_s_d;
            duty_s_q <= duty_s_d;
            pcnt_q   <= pcnt_d;
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            ptick_q  <= ptick_d;
            rd_q     <= rd_d;
        end
    end

    assign rd_data     = rd_q;
    assign pwm_out     = pwm_q;
    assign period_tick = ptick_q;

endmodule
`default_nettype wire
